// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared constants, control bundle type and the load-use
//               compare helper for the 5-stage RV32 hazard control unit.
// Contents    : XLEN, REG_X0, FSM state encodings (ST_RUN / ST_FREEZE /
//               ST_ERROR), hazard_ctrl_t control bundle, load_use_hit().
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

   localparam int XLEN = 32;

   localparam logic [4:0] REG_X0 = 5'd0;

   // Hazard FSM state encodings.
   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_FREEZE = 2'd1;
   localparam logic [1:0] ST_ERROR  = 2'd2;

   // All pipeline control strobes produced in one cycle, grouped so that a
   // whole decision can be selected with a single assignment.
   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic if_id_flush;
      logic id_ex_flush;
      logic pipe_freeze;
      logic pc_redirect;
   } hazard_ctrl_t;

   localparam hazard_ctrl_t CTRL_IDLE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   // Memory wait: hold the PC, IF/ID and everything from ID/EX onwards.
   localparam hazard_ctrl_t CTRL_FREEZE = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   // Taken branch / jump: kill the two younger instructions, load the PC.
   localparam hazard_ctrl_t CTRL_REDIR  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   // Load-use: hold PC and IF/ID one cycle, bubble into ID/EX.
   localparam hazard_ctrl_t CTRL_BUBBLE = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

   // True when the load in EX produces a register the ID instruction reads.
   // x0 is never a real dependency, and an unused source field may hold
   // arbitrary bits, so both are filtered out.
   function automatic logic load_use_hit(
      input logic       mem_to_reg,
      input logic       reg_write,
      input logic [4:0] rd,
      input logic [4:0] rs1,
      input logic       uses_rs1,
      input logic [4:0] rs2,
      input logic       uses_rs2
   );
      logic src_match;
      src_match    = (uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd));
      load_use_hit = mem_to_reg && reg_write && (rd != REG_X0) && src_match;
   endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up counter that sticks at all-ones instead of wrapping.
// Ports       : clk   - clock, rising edge
//               rst   - synchronous active-high reset, clears count
//               inc   - add one this cycle (ignored once saturated)
//               count - current value, W bits
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + 1'b1;
      end
   end

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_control_unit
// Description : Stall / flush / PC-redirect generation for the 5-stage RV32
//               pipeline. Handles load-use bubbles, EX-resolved redirects
//               and data-memory wait states, with a freeze FSM that raises
//               a sticky fatal flag if memory stays busy too long. Two
//               saturating counters expose stall and flush activity.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               id_rs1/rs2, id_uses_rs1/rs2 - ID source operands
//               ex_rd, ex_reg_write, ex_mem_to_reg - EX destination / load
//               ex_redirect, ex_target - taken branch/jump and its target
//               mem_busy          - MEM stage access not completing
//               pc_stall, if_id_stall, if_id_flush, id_ex_flush,
//               pipe_freeze, pc_redirect, pc_target - pipeline controls
//               mem_timeout_err   - sticky memory timeout flag
//               stall_cycles, flush_events - performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 64,
   parameter int TO_W        = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic [4:0]        ex_rd,
   input  logic              ex_reg_write,
   input  logic              ex_mem_to_reg,
   input  logic              ex_redirect,
   input  logic [XLEN-1:0]   ex_target,
   input  logic              mem_busy,
   output logic              pc_stall,
   output logic              if_id_stall,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              pipe_freeze,
   output logic              pc_redirect,
   output logic [XLEN-1:0]   pc_target,
   output logic              mem_timeout_err,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_events
);

   localparam logic [TO_W-1:0] BUSY_ONE = TO_W'(1);
   localparam logic [TO_W-1:0] BUSY_MAX = '1;

   logic [1:0]      state;
   logic [1:0]      state_next;
   logic [TO_W-1:0] busy_cnt;
   logic [TO_W-1:0] busy_cnt_next;
   logic [TO_W-1:0] busy_cnt_inc;
   logic            load_use;
   logic            timeout_hit;
   logic            freeze_cycle;
   logic            stall_inc;
   logic            flush_inc;
   hazard_ctrl_t    run_ctrl;
   hazard_ctrl_t    ctrl;

   assign load_use = load_use_hit(ex_mem_to_reg, ex_reg_write, ex_rd,
                                  id_rs1, id_uses_rs1, id_rs2, id_uses_rs2);

   assign busy_cnt_inc = (busy_cnt == BUSY_MAX) ? busy_cnt : busy_cnt + 1'b1;

   // busy_cnt counts FREEZE-state busy cycles only; the RUN entry cycle
   // preloads it with 1, so reaching MEM_TIMEOUT while still busy means
   // MEM_TIMEOUT+1 consecutive busy cycles have been seen.
   if (MEM_TIMEOUT != 0) begin : g_timeout
      localparam logic [TO_W-1:0] TIMEOUT_CNT = TO_W'(MEM_TIMEOUT);
      assign timeout_hit = (busy_cnt == TIMEOUT_CNT);
   end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
   end

   // Decision when memory is not holding the pipe: a redirect kills the
   // younger instructions, including one that would otherwise stall on the
   // load, so it outranks load-use.
   always_comb begin
      run_ctrl = CTRL_IDLE;
      if (ex_redirect) begin
         run_ctrl = CTRL_REDIR;
      end else if (load_use) begin
         run_ctrl = CTRL_BUBBLE;
      end
   end

   always_comb begin
      ctrl          = CTRL_IDLE;
      state_next    = state;
      busy_cnt_next = busy_cnt;
      freeze_cycle  = 1'b0;

      case (state)
         ST_RUN: begin
            if (mem_busy) begin
               // Redirect / load-use are simply not acted on; EX and ID are
               // held, so they are seen again once memory is released.
               ctrl          = CTRL_FREEZE;
               freeze_cycle  = 1'b1;
               state_next    = ST_FREEZE;
               busy_cnt_next = BUSY_ONE;
            end else begin
               ctrl = run_ctrl;
            end
         end
         ST_FREEZE: begin
            if (mem_busy) begin
               ctrl          = CTRL_FREEZE;
               freeze_cycle  = 1'b1;
               busy_cnt_next = busy_cnt_inc;
               if (timeout_hit) begin
                  state_next = ST_ERROR;
               end
            end else begin
               ctrl          = run_ctrl;
               busy_cnt_next = '0;
               state_next    = ST_RUN;
            end
         end
         ST_ERROR: begin
            ctrl = CTRL_FREEZE;
         end
         default: begin
            // Unreachable encoding: return to a known state.
            state_next    = ST_RUN;
            busy_cnt_next = '0;
         end
      endcase

      if (rst) begin
         ctrl         = CTRL_IDLE;
         freeze_cycle = 1'b0;
      end
   end

   assign pc_stall    = ctrl.pc_stall;
   assign if_id_stall = ctrl.if_id_stall;
   assign if_id_flush = ctrl.if_id_flush;
   assign id_ex_flush = ctrl.id_ex_flush;
   assign pipe_freeze = ctrl.pipe_freeze;
   assign pc_redirect = ctrl.pc_redirect;
   assign pc_target   = ctrl.pc_redirect ? ex_target : '0;

   // A bubble is the only id_ex_flush that is not part of a redirect.
   // ERROR cycles are not freeze_cycle, so the counters hold there.
   assign stall_inc = freeze_cycle || (ctrl.id_ex_flush && !ctrl.pc_redirect);
   assign flush_inc = ctrl.pc_redirect;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_RUN;
         busy_cnt        <= '0;
         mem_timeout_err <= 1'b0;
      end else begin
         state    <= state_next;
         busy_cnt <= busy_cnt_next;
         if (state_next == ST_ERROR) begin
            mem_timeout_err <= 1'b1;
         end
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cycles)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc),
      .count (flush_events)
   );

endmodule : hazard_control_unit
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_control_unit
// Description : Directed self-checking bench for hazard_control_unit.
//               Small counter width so saturation is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_control_unit;
   import hazard_pkg::*;

   localparam int CNT_W       = 4;
   localparam int MEM_TIMEOUT = 4;
   localparam int TO_W        = 8;

   // Control vector order: {pc_stall, if_id_stall, if_id_flush,
   //                        id_ex_flush, pipe_freeze, pc_redirect}
   localparam logic [5:0] C_NONE   = 6'b000000;
   localparam logic [5:0] C_BUBBLE = 6'b110100;
   localparam logic [5:0] C_REDIR  = 6'b001101;
   localparam logic [5:0] C_FREEZE = 6'b110010;

   logic              clk = 1'b0;
   logic              rst;
   logic [4:0]        id_rs1, id_rs2, ex_rd;
   logic              id_uses_rs1, id_uses_rs2;
   logic              ex_reg_write, ex_mem_to_reg, ex_redirect, mem_busy;
   logic [31:0]       ex_target;
   logic              pc_stall, if_id_stall, if_id_flush, id_ex_flush;
   logic              pipe_freeze, pc_redirect, mem_timeout_err;
   logic [31:0]       pc_target;
   logic [CNT_W-1:0]  stall_cycles, flush_events;

   int checks = 0;
   int errors = 0;

   hazard_control_unit #(
      .CNT_W       (CNT_W),
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TO_W        (TO_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_uses_rs1     (id_uses_rs1),
      .id_uses_rs2     (id_uses_rs2),
      .ex_rd           (ex_rd),
      .ex_reg_write    (ex_reg_write),
      .ex_mem_to_reg   (ex_mem_to_reg),
      .ex_redirect     (ex_redirect),
      .ex_target       (ex_target),
      .mem_busy        (mem_busy),
      .pc_stall        (pc_stall),
      .if_id_stall     (if_id_stall),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .pipe_freeze     (pipe_freeze),
      .pc_redirect     (pc_redirect),
      .pc_target       (pc_target),
      .mem_timeout_err (mem_timeout_err),
      .stall_cycles    (stall_cycles),
      .flush_events    (flush_events)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_ctrl(input string tag, input logic [5:0] exp);
      check(tag, {26'd0, pc_stall, if_id_stall, if_id_flush, id_ex_flush,
                  pipe_freeze, pc_redirect}, {26'd0, exp});
   endtask

   // Inputs change 1 time unit after a rising edge, checks follow 1 unit
   // later, well clear of both clock edges.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0;
      ex_redirect = 1'b0; ex_target = 32'd0; mem_busy = 1'b0;
   endtask

   task automatic set_load(input logic [4:0] rd);
      ex_mem_to_reg = 1'b1; ex_reg_write = 1'b1; ex_rd = rd;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      tick();

      // Reset dominates live hazards on the inputs.
      mem_busy = 1'b1; ex_redirect = 1'b1; ex_target = 32'hABCD_0000;
      set_load(5'd3); id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
      settle();
      check_ctrl("rst_ctrl", C_NONE);
      check("rst_target", pc_target, 32'd0);
      tick();
      check("rst_stall_cnt", {28'd0, stall_cycles}, 32'd0);
      check("rst_flush_cnt", {28'd0, flush_events}, 32'd0);
      check("rst_err", {31'd0, mem_timeout_err}, 32'd0);
      check("rst_state", {30'd0, dut.state}, {30'd0, ST_RUN});
      idle();
      rst = 1'b0;
      settle();
      check_ctrl("idle_ctrl", C_NONE);

      // Load-use through rs2.
      tick();
      set_load(5'd5); id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
      settle();
      check_ctrl("lu_rs2_ctrl", C_BUBBLE);
      check("lu_rs2_target", pc_target, 32'd0);
      tick();
      idle();
      settle();
      check_ctrl("lu_next_ctrl", C_NONE);
      check("lu_stall_cnt", {28'd0, stall_cycles}, 32'd1);

      // x0 destination and unused-source filters.
      set_load(5'd0); id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
      settle();
      check_ctrl("x0_filter", C_NONE);
      set_load(5'd7); id_rs1 = 5'd7; id_uses_rs1 = 1'b0;
      settle();
      check_ctrl("unused_rs1_filter", C_NONE);
      // Non-load writer never needs a bubble.
      ex_mem_to_reg = 1'b0; id_uses_rs1 = 1'b1;
      settle();
      check_ctrl("non_load_filter", C_NONE);
      // Load through rs1 does.
      ex_mem_to_reg = 1'b1;
      settle();
      check_ctrl("lu_rs1_ctrl", C_BUBBLE);
      tick();
      idle();
      settle();
      check("filter_stall_cnt", {28'd0, stall_cycles}, 32'd2);

      // Redirect beats a simultaneous load-use.
      do_reset();
      set_load(5'd9); id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
      ex_redirect = 1'b1; ex_target = 32'h0000_0100;
      settle();
      check_ctrl("redir_ctrl", C_REDIR);
      check("redir_target", pc_target, 32'h0000_0100);
      tick();
      idle();
      ex_target = 32'h1234_5678;
      settle();
      check("redir_flush_cnt", {28'd0, flush_events}, 32'd1);
      check("redir_stall_cnt", {28'd0, stall_cycles}, 32'd0);
      check("no_redir_target_zero", pc_target, 32'd0);

      // Freeze for 3 cycles with a pending redirect, then release.
      do_reset();
      mem_busy = 1'b1; ex_redirect = 1'b1; ex_target = 32'h0000_0200;
      for (int i = 0; i < 3; i++) begin
         settle();
         check_ctrl($sformatf("freeze_ctrl_%0d", i), C_FREEZE);
         check($sformatf("freeze_target_%0d", i), pc_target, 32'd0);
         tick();
      end
      mem_busy = 1'b0;
      settle();
      check_ctrl("deferred_redir_ctrl", C_REDIR);
      check("deferred_redir_target", pc_target, 32'h0000_0200);
      check("freeze_stall_cnt", {28'd0, stall_cycles}, 32'd3);
      tick();
      idle();
      settle();
      check("deferred_flush_cnt", {28'd0, flush_events}, 32'd1);
      check("deferred_state", {30'd0, dut.state}, {30'd0, ST_RUN});

      // Timeout: 5 busy cycles reach ERROR, flag visible on the 6th.
      do_reset();
      mem_busy = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         settle();
         check_ctrl($sformatf("to_freeze_%0d", i), C_FREEZE);
         check($sformatf("to_err_low_%0d", i), {31'd0, mem_timeout_err}, 32'd0);
         tick();
      end
      check("to_err_set", {31'd0, mem_timeout_err}, 32'd1);
      check_ctrl("to_err_ctrl", C_FREEZE);
      check("to_stall_cnt", {28'd0, stall_cycles}, 32'd5);
      mem_busy = 1'b0; ex_redirect = 1'b1; ex_target = 32'h0000_0300;
      settle();
      check_ctrl("err_stuck_ctrl", C_FREEZE);
      check("err_target", pc_target, 32'd0);
      tick();
      tick();
      check("err_stall_hold", {28'd0, stall_cycles}, 32'd5);
      check("err_flush_hold", {28'd0, flush_events}, 32'd0);
      check("err_sticky", {31'd0, mem_timeout_err}, 32'd1);
      rst = 1'b1;
      settle();
      check_ctrl("err_rst_ctrl", C_NONE);
      tick();
      rst = 1'b0;
      idle();
      settle();
      check("err_cleared", {31'd0, mem_timeout_err}, 32'd0);
      check("err_rst_state", {30'd0, dut.state}, {30'd0, ST_RUN});
      check("err_rst_stall_cnt", {28'd0, stall_cycles}, 32'd0);
      check_ctrl("err_rst_idle", C_NONE);

      // Reset in the middle of a freeze.
      tick();
      mem_busy = 1'b1;
      tick();
      rst = 1'b1;
      settle();
      check_ctrl("midfreeze_rst_ctrl", C_NONE);
      tick();
      rst = 1'b0;
      mem_busy = 1'b0;
      settle();
      check_ctrl("midfreeze_after_ctrl", C_NONE);
      check("midfreeze_busy_cnt", {24'd0, dut.busy_cnt}, 32'd0);
      check("midfreeze_state", {30'd0, dut.state}, {30'd0, ST_RUN});
      check("midfreeze_stall_cnt", {28'd0, stall_cycles}, 32'd0);
      mem_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         check_ctrl($sformatf("burst4_freeze_%0d", i), C_FREEZE);
         tick();
      end
      mem_busy = 1'b0;
      settle();
      check_ctrl("burst4_release", C_NONE);
      tick();
      check("burst4_no_err", {31'd0, mem_timeout_err}, 32'd0);
      check("burst4_state", {30'd0, dut.state}, {30'd0, ST_RUN});
      check("burst4_stall_cnt", {28'd0, stall_cycles}, 32'd4);

      // Counter saturation at 2**CNT_W-1.
      do_reset();
      set_load(5'd11); id_rs2 = 5'd11; id_uses_rs2 = 1'b1;
      for (int i = 0; i < 17; i++) tick();
      check("stall_saturate", {28'd0, stall_cycles}, 32'd15);
      idle();
      ex_redirect = 1'b1; ex_target = 32'h0000_0040;
      for (int i = 0; i < 17; i++) tick();
      check("flush_saturate", {28'd0, flush_events}, 32'd15);
      check("stall_sat_hold", {28'd0, stall_cycles}, 32'd15);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_hazard_control_unit
`default_nettype wire
